data_memory: RTL and testbench
==============================

DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter LATENCY, default 5: clock cycles from request acceptance to completion; legal range 2..15.
REQ-002 Parameter INDEX_BITS, default 8: block index width; depth = 2^INDEX_BITS blocks of 128 bits.
REQ-003 clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 mem_read  input  1  block read request; held high by the cache until mem_busywait falls.
REQ-006 mem_write  input  1  block write request; held high by the cache until mem_busywait falls.
REQ-007 mem_address  input  28  block address, i.e. byte address [31:4].
REQ-008 mem_writedata  input  128  write block; word 0 in [31:0], word 3 in [127:96].
REQ-009 mem_readdata  output  128  read block, same word ordering as mem_writedata.
REQ-010 mem_busywait  output  1  high while a request is in service.
REQ-011 read_count  output  32  completed reads since reset.
REQ-012 write_count  output  32  completed writes since reset.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, BUSY and DONE.
REQ-014 IDLE: if mem_read or mem_write is high at a rising edge, the block SHALL go to BUSY, set mem_busywait=1, load the counter with LATENCY-1, and latch mem_address[INDEX_BITS-1:0], mem_writedata and the operation type.
REQ-015 mem_busywait SHALL be registered, so it rises one rising edge after the request is sampled, which is before the cache's next falling-edge sample.
REQ-016 BUSY: the counter SHALL decrement by 1 per cycle.
REQ-017 On the edge where the counter equals 1, the block SHALL complete the operation: read loads mem_readdata from the latched index; write stores the latched data at the latched index.
REQ-018 On that same completing edge, the block SHALL clear mem_busywait, increment the matching counter and go to DONE.
REQ-019 From acceptance to mem_busywait low SHALL take exactly LATENCY rising edges.
REQ-020 DONE SHALL last exactly one cycle with mem_busywait=0 and requests ignored (this absorbs the request still held by the cache), then return to IDLE.
REQ-021 A new request SHALL be accepted only from IDLE.
REQ-022 Changes to mem_address, mem_writedata, mem_read or mem_write during BUSY SHALL NOT affect the transaction in progress.
REQ-023 If mem_read and mem_write are both high at acceptance, the read SHALL be performed and the write SHALL be discarded; write_count SHALL NOT increment.
REQ-024 If the request is withdrawn during BUSY, the transaction SHALL still complete and be counted.
REQ-025 mem_address[27:INDEX_BITS] SHALL be ignored, so addresses alias modulo depth.
REQ-026 mem_readdata SHALL hold its last value until the next read completes; writes SHALL NOT change it.
REQ-027 read_count and write_count SHALL wrap from 2^32-1 to 0.

Reset
REQ-028 While reset is low, the block SHALL force state=IDLE, mem_busywait=0, counter=0, mem_readdata=0, read_count=0 and write_count=0, independent of clock.
REQ-029 Reset asserted mid-BUSY SHALL abort the transaction: no array write and no count increment.
REQ-030 Array contents SHALL NOT be cleared by reset and are undefined after power-up.
REQ-031 The first rising edge after reset deasserts SHALL be able to accept a request.

Verification
REQ-032 Reset low, then high; mem_write=1, addr=28'h0000005, data=128'hDDDD...AAAA -> mem_busywait high one edge later, low exactly 5 edges after acceptance, write_count=1.
REQ-033 mem_read=1, addr=28'h0000005 -> mem_readdata=128'hDDDD...AAAA when mem_busywait falls, read_count=1, one DONE cycle with mem_busywait=0.
REQ-034 Write addr 28'h0000105 with 128'h1; read addr 28'h0000005 -> 128'h1 (alias with INDEX_BITS=8).
REQ-035 mem_read=mem_write=1, addr 7 -> read performed, block 7 unchanged, write_count unchanged.
REQ-036 mem_address and mem_writedata changed on cycle 2 of BUSY -> originally latched index and data used.
REQ-037 Reset pulsed low on cycle 3 of a write -> mem_busywait=0 immediately; target block keeps its old value (checked by a read); counts=0.

Source files
------------

// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
//   Block-organised backing store for a cache. Each request is serviced with a
//   fixed latency and reported through a busywait handshake. The array holds
//   2^INDEX_BITS blocks of 128 bits. Only the low INDEX_BITS of the block
//   address are decoded, so higher addresses alias onto the same blocks.
//
// Handshake: the cache raises mem_read or mem_write (with address and data
//   valid) and holds them until it sees mem_busywait low. A request is taken
//   only when the FSM is IDLE. mem_busywait rises on the accepting edge and
//   falls on the completing edge. The DONE cycle that follows ignores the
//   request the cache is still holding.
//
// Parameters:
//   LATENCY    - rising edges from acceptance to completion, counting the
//                accepting edge as the first one (legal 2..15).
//   INDEX_BITS - block index width.
//
// Ports:
//   clock         - sole clock, rising edge.
//   reset         - asynchronous, active-low.
//   mem_read      - block read request.
//   mem_write     - block write request.
//   mem_address   - block address (byte address [31:4]).
//   mem_writedata - write block, word 0 in [31:0].
//   mem_readdata  - read block, held until the next read completes.
//   mem_busywait  - high while a request is in service.
//   read_count    - completed reads since reset (wraps).
//   write_count   - completed writes since reset (wraps).
//   state         - current FSM state, for observation.
// -----------------------------------------------------------------------------
module data_memory #(
  parameter int LATENCY    = 5,
  parameter int INDEX_BITS = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [27:0]  mem_address,
  input  logic [127:0] mem_writedata,
  output logic [127:0] mem_readdata,
  output logic         mem_busywait,
  output logic [31:0]  read_count,
  output logic [31:0]  write_count,
  output logic [1:0]   state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int         DEPTH = 1 << INDEX_BITS;
  localparam logic [3:0] LOAD  = 4'(LATENCY - 1);

  logic [127:0]          mem_array [DEPTH];

  logic [3:0]            count;
  logic [INDEX_BITS-1:0] index_q;
  logic [127:0]          data_q;
  logic                  op_read_q;
  logic                  op_write_q;

  logic                  accept;
  logic                  complete;

  // Upper address bits are deliberately not decoded (aliasing).
  logic                  unused_addr_bits;
  assign unused_addr_bits = ^mem_address[27:INDEX_BITS];

  assign accept   = (state == IDLE) && (mem_read || mem_write);
  assign complete = (state == BUSY) && (count == 4'd1);

  // Control and observable outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      mem_busywait <= 1'b0;
      count        <= 4'd0;
      mem_readdata <= '0;
      read_count   <= '0;
      write_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state        <= BUSY;
            mem_busywait <= 1'b1;
            count        <= LOAD;
          end
        end
        BUSY: begin
          if (complete) begin
            state        <= DONE;
            mem_busywait <= 1'b0;
            count        <= 4'd0;
            if (op_read_q) begin
              mem_readdata <= mem_array[index_q];
              read_count   <= read_count + 32'd1;
            end
            if (op_write_q) begin
              write_count <= write_count + 32'd1;
            end
          end else begin
            count <= count - 4'd1;
          end
        end
        DONE: begin
          // One dead cycle absorbs the request the cache still holds.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Transaction capture. Only loaded on acceptance, so bus changes during
  // BUSY cannot disturb the request in flight. A simultaneous read and write
  // is treated as a read; the write half is dropped here.
  always_ff @(posedge clock) begin
    if (accept) begin
      index_q    <= mem_address[INDEX_BITS-1:0];
      data_q     <= mem_writedata;
      op_read_q  <= mem_read;
      op_write_q <= mem_write & ~mem_read;
    end
  end

  // Array write on the completing edge. Reset forces state to IDLE
  // asynchronously, so an aborted write never reaches the array.
  always_ff @(posedge clock) begin
    if (complete && op_write_q) begin
      mem_array[index_q] <= data_q;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// -----------------------------------------------------------------------------
// tb_data_memory
//   Self-checking bench for data_memory. A cache-like driver issues block
//   requests on the falling edge and samples on the falling edge. A reference
//   memory array plus expected counters predicts every completion; expected
//   read blocks travel through exp_q.
// -----------------------------------------------------------------------------
module tb_data_memory;

  localparam int LATENCY    = 5;
  localparam int INDEX_BITS = 8;
  localparam int DEPTH      = 1 << INDEX_BITS;
  localparam int BUDGET     = 40;

  localparam logic [1:0] ST_IDLE = 2'd0;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic         clock = 1'b0;
  logic         reset;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
  logic [31:0]  read_count;
  logic [31:0]  write_count;
  logic [1:0]   state;

  always #5 clock = ~clock;

  data_memory #(
    .LATENCY    (LATENCY),
    .INDEX_BITS (INDEX_BITS)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait),
    .read_count    (read_count),
    .write_count   (write_count),
    .state         (state)
  );

  // ---------------------------------------------------------------------------
  // Reference model / scoreboard
  // ---------------------------------------------------------------------------
  logic [127:0] ref_mem [DEPTH];
  logic [127:0] exp_q [$];
  logic [127:0] exp_last_rd;
  logic [31:0]  exp_rc;
  logic [31:0]  exp_wc;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drop_request();
    mem_read      = 1'b0;
    mem_write     = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one complete cache transaction. Called just after a falling edge;
  // returns just after a falling edge. perturb scrambles the bus (including
  // withdrawing or changing the request) on the second BUSY cycle. hold_done
  // keeps the request asserted through the DONE cycle.
  // ---------------------------------------------------------------------------
  task automatic txn(input logic rd, input logic wr, input logic [27:0] addr,
                     input logic [127:0] data, input bit perturb,
                     input bit hold_done);
    int edges;
    int idx;
    idx           = int'(addr) % DEPTH;
    mem_read      = rd;
    mem_write     = wr;
    mem_address   = addr;
    mem_writedata = data;
    if (rd) exp_q.push_back(ref_mem[idx]);

    @(posedge clock);
    edges = 1;
    @(negedge clock);
    check("busy_rise", 128'(mem_busywait), 128'(1));
    if (perturb) begin
      mem_address   = 28'($urandom);
      mem_writedata = rand_block();
      mem_read      = 1'($urandom);
      mem_write     = 1'($urandom);
    end
    while (mem_busywait === 1'b1 && edges < BUDGET) begin
      @(posedge clock);
      edges++;
      @(negedge clock);
    end
    check("latency", 128'(edges), 128'(LATENCY));

    if (rd) begin
      exp_last_rd = exp_q.pop_front();
      exp_rc      = exp_rc + 32'd1;
    end else if (wr) begin
      ref_mem[idx] = data;
      exp_wc       = exp_wc + 32'd1;
    end
    check("readdata", mem_readdata, exp_last_rd);
    check("read_count", 128'(read_count), 128'(exp_rc));
    check("write_count", 128'(write_count), 128'(exp_wc));

    if (!hold_done) drop_request();
    @(posedge clock);
    @(negedge clock);
    check("done_busy_low", 128'(mem_busywait), 128'(0));
    check("done_to_idle", 128'(state), 128'(ST_IDLE));
    drop_request();
  endtask

  // Write aborted by reset on the third cycle of BUSY.
  task automatic reset_abort(input logic [27:0] addr, input logic [127:0] data);
    mem_write     = 1'b1;
    mem_read      = 1'b0;
    mem_address   = addr;
    mem_writedata = data;
    @(posedge clock);
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    exp_rc      = 32'd0;
    exp_wc      = 32'd0;
    exp_last_rd = '0;
    check("abort_busy", 128'(mem_busywait), 128'(0));
    check("abort_state", 128'(state), 128'(ST_IDLE));
    check("abort_rc", 128'(read_count), 128'(exp_rc));
    check("abort_wc", 128'(write_count), 128'(exp_wc));
    check("abort_readdata", mem_readdata, exp_last_rd);
    drop_request();
    @(negedge clock);
    reset = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [127:0] pat_dcba;
  logic [27:0]  a;
  logic         r;
  logic         w;

  initial begin
    pat_dcba      = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    reset         = 1'b0;
    drop_request();
    mem_address   = '0;
    mem_writedata = '0;
    exp_rc        = '0;
    exp_wc        = '0;
    exp_last_rd   = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 'x;

    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 128'(mem_busywait), 128'(0));
    check("rst_state", 128'(state), 128'(ST_IDLE));
    check("rst_readdata", mem_readdata, 128'(0));
    check("rst_rc", 128'(read_count), 128'(0));
    check("rst_wc", 128'(write_count), 128'(0));

    // Request presented with reset release: first edge must accept it.
    @(negedge clock);
    reset = 1'b1;
    txn(1'b0, 1'b1, 28'h0000005, pat_dcba, 1'b0, 1'b0);
    txn(1'b1, 1'b0, 28'h0000005, '0, 1'b0, 1'b1);

    // Alias: 0x105 and 0x005 share block 5.
    txn(1'b0, 1'b1, 28'h0000105, 128'h1, 1'b0, 1'b0);
    txn(1'b1, 1'b0, 28'h0000005, '0, 1'b0, 1'b0);

    // Fill the whole array so every later read has a known expectation.
    for (int i = 0; i < DEPTH; i++) begin
      txn(1'b0, 1'b1, 28'(i), rand_block(), 1'b0, 1'($urandom_range(0, 1)));
    end

    // Read and write together: read wins, block 7 untouched.
    txn(1'b1, 1'b1, 28'h0000007, rand_block(), 1'b0, 1'b0);
    txn(1'b1, 1'b0, 28'h0000007, '0, 1'b0, 1'b0);

    // Bus scrambled mid-BUSY: latched index and data must be used.
    txn(1'b0, 1'b1, 28'h0000033, rand_block(), 1'b1, 1'b0);
    txn(1'b1, 1'b0, 28'h0000033, '0, 1'b0, 1'b0);

    // Reset mid-write leaves the block alone; a read confirms it.
    reset_abort(28'h0000042, rand_block());
    txn(1'b1, 1'b0, 28'h0000042, '0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      a = 28'($urandom);
      r = 1'($urandom_range(0, 1));
      w = r ? 1'($urandom_range(0, 1)) : 1'b1;
      txn(r, w, a, rand_block(), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) @(negedge clock);
    end

    check("exp_q_empty", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
